// File: rtl/wta_pkg.sv
// Shared helpers for the k-winner-take-all block: winner popcount and
// gamma counter width.
package wta_pkg;

  // Widest spike vector the popcount helper accepts.
  localparam int MAX_LINES = 64;

  function automatic int popcount(input logic [MAX_LINES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_LINES; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  function automatic int gamma_w(input int g);
    return (g > 1) ? $clog2(g) : 1;
  endfunction

endpackage

// File: rtl/wta_prio_pick.sv
// Combinational picker: selects up to limit_i set bits of vec_i, scanning
// upward from index rot_i with wrap-around.
module wta_prio_pick
  import wta_pkg::*;
#(
  parameter int N  = 16,
  parameter int LW = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  input  logic [LW-1:0] limit_i,
  input  logic [IW-1:0] rot_i,
  output logic [N-1:0]  sel_o
);

  always_comb begin
    int            taken;
    logic [IW-1:0] idx;
    sel_o = '0;
    taken = 0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      idx = IW'((int'(rot_i) + j) % N);
      if (vec_i[idx] && (taken < int'(limit_i))) begin
        sel_o[idx] = 1'b1;
        taken++;
      end
    end
  end

endmodule

// File: rtl/wta_k.sv
// k-winner-take-all over spike lines, evaluated per gamma cycle.
// Define WTA_RR_TIE_EN to rotate tie-break priority by one line per gamma cycle.
module wta_k
  import wta_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_INPUTS        = 16,
  parameter int K                 = 2
) (
  input  logic                     aclk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_INPUTS-1:0]    input_spikes,
  output logic [NUM_INPUTS-1:0]    output_spikes,
  output logic                     gamma_start,
  output logic [$clog2(K+1)-1:0]   win_count
);

  localparam int GW  = gamma_w(GAMMA_CYCLE_WIDTH);
  localparam int WCW = $clog2(K+1);
  localparam int PCW = $clog2(PULSE_WIDTH+1);
  localparam int IW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [GW-1:0]         gamma_cnt_q, gamma_cnt_d;
  logic [NUM_INPUTS-1:0] in_q, won_q, won_d;
  logic [NUM_INPUTS-1:0] rise, cand, sel;
  logic [WCW-1:0]        win_q, win_d, limit;
  logic [PCW-1:0]        pulse_q [NUM_INPUTS];
  logic [PCW-1:0]        pulse_d [NUM_INPUTS];
  logic [IW-1:0]         rot;
  logic                  wrap;

  assign rise  = input_spikes & ~in_q;
  assign cand  = rise & ~won_q;
  assign limit = WCW'(K) - win_q;
  assign wrap  = (gamma_cnt_q == GW'(GAMMA_CYCLE_WIDTH-1));

  wta_prio_pick #(
    .N  (NUM_INPUTS),
    .LW (WCW),
    .IW (IW)
  ) u_pick (
    .vec_i   (cand),
    .limit_i (limit),
    .rot_i   (rot),
    .sel_o   (sel)
  );

`ifdef WTA_RR_TIE_EN
  logic [IW-1:0] rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (en && wrap) begin
      rr_d = (rr_q == IW'(NUM_INPUTS-1)) ? '0 : rr_q + IW'(1);
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  assign rot = rr_q;
`else
  assign rot = '0;
`endif

  // The wrap clear takes precedence over any selection in the last gamma cycle.
  always_comb begin
    gamma_cnt_d = gamma_cnt_q;
    won_d       = won_q;
    win_d       = win_q;
    pulse_d     = pulse_q;
    if (en) begin
      if (wrap) begin
        gamma_cnt_d = '0;
        won_d       = '0;
        win_d       = '0;
        for (int i = 0; i < NUM_INPUTS; i++) pulse_d[i] = '0;
      end else begin
        gamma_cnt_d = gamma_cnt_q + GW'(1);
        won_d       = won_q | sel;
        win_d       = win_q + WCW'(popcount(MAX_LINES'(sel)));
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (sel[i])                  pulse_d[i] = PCW'(PULSE_WIDTH);
          else if (pulse_q[i] != '0)   pulse_d[i] = pulse_q[i] - PCW'(1);
        end
      end
    end
  end

  // in_q resets high so lines held high through reset never look like a rise.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      gamma_cnt_q <= '0;
      in_q        <= '1;
      won_q       <= '0;
      win_q       <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) pulse_q[i] <= '0;
    end else begin
      gamma_cnt_q <= gamma_cnt_d;
      in_q        <= input_spikes;
      won_q       <= won_d;
      win_q       <= win_d;
      pulse_q     <= pulse_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) output_spikes[i] = (pulse_q[i] != '0);
  end

  assign gamma_start = (gamma_cnt_q == '0);
  assign win_count   = win_q;

endmodule

// File: tb/tb_wta_k.sv
// Directed bench for wta_k: G=16, PW=4, 16 lines; a K=2 instance plus a K=1
// instance for tie-break ordering.
module tb_wta_k;

  logic        aclk;
  logic        rst_n;
  logic        en;
  logic        en2;
  logic [15:0] in1, in2;
  logic [15:0] out1, out2;
  logic        gs1, gs2;
  logic [1:0]  wc1;
  logic [0:0]  wc2;

  int checks = 0;
  int passed = 0;
  int cnt    = 0;

  wta_k #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(4), .NUM_INPUTS(16), .K(2)) dut (
    .aclk          (aclk),
    .rst_n         (rst_n),
    .en            (en),
    .input_spikes  (in1),
    .output_spikes (out1),
    .gamma_start   (gs1),
    .win_count     (wc1)
  );

  wta_k #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(4), .NUM_INPUTS(16), .K(1)) dut_k1 (
    .aclk          (aclk),
    .rst_n         (rst_n),
    .en            (en2),
    .input_spikes  (in2),
    .output_spikes (out2),
    .gamma_start   (gs2),
    .win_count     (wc2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // cnt tracks the gamma count of the window currently presented.
  task automatic tick();
    logic e;
    e = en;
    @(posedge aclk);
    #1;
    if (e) cnt = (cnt + 1) % 16;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; en2 = 1'b1;
    in1 = 16'h0001; in2 = 16'h0000;
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (out1 !== 16'h0000) $display("FAIL rst_out got %h want %h", out1, 16'h0000); else passed++;
    checks++; if (gs1 !== 1'b1) $display("FAIL rst_gamma_start got %b want 1", gs1); else passed++;
    checks++; if (wc1 !== 2'd0) $display("FAIL rst_win_count got %0d want 0", wc1); else passed++;
    rst_n = 1'b1;
    cnt = 0;
  endtask

  task automatic test_held_line();
    logic [15:0] stim [16];
    logic [15:0] exp_o [16];
    logic [1:0]  exp_w [16];
    for (int c = 0; c < 16; c++) begin
      stim[c] = 16'h0; exp_o[c] = 16'h0; exp_w[c] = (c >= 4) ? 2'd1 : 2'd0;
      if (c >= 4 && c <= 7) exp_o[c] = 16'h0001;
    end
    stim[0] = 16'h0001;
    stim[3] = 16'h0001;
    for (int c = 0; c < 16; c++) begin
      checks++; if (out1 !== exp_o[c]) $display("FAIL held_out c=%0d got %h want %h", c, out1, exp_o[c]); else passed++;
      checks++; if (wc1 !== exp_w[c]) $display("FAIL held_wc c=%0d got %0d want %0d", c, wc1, exp_w[c]); else passed++;
      checks++; if (gs1 !== (c == 0)) $display("FAIL held_gs c=%0d got %b want %b", c, gs1, (c == 0)); else passed++;
      in1 = stim[c];
      tick();
    end
  endtask

  task automatic test_tie();
    logic [15:0] exp_o [16];
    logic [1:0]  exp_w [16];
    for (int c = 0; c < 16; c++) begin
      exp_o[c] = (c >= 3 && c <= 6) ? 16'h0028 : 16'h0000;
      exp_w[c] = (c >= 3) ? 2'd2 : 2'd0;
    end
    for (int c = 0; c < 16; c++) begin
      checks++; if (out1 !== exp_o[c]) $display("FAIL tie_out c=%0d got %h want %h", c, out1, exp_o[c]); else passed++;
      checks++; if (wc1 !== exp_w[c]) $display("FAIL tie_wc c=%0d got %0d want %0d", c, wc1, exp_w[c]); else passed++;
      in1 = (c == 2) ? 16'h0228 : 16'h0000;
      tick();
    end
  endtask

  task automatic test_inhibit();
    logic [15:0] stim [16];
    logic [15:0] exp_o [16];
    logic [1:0]  exp_w [16];
    for (int c = 0; c < 16; c++) begin
      stim[c]  = 16'h0;
      exp_o[c] = (c >= 2 && c <= 5) ? 16'h0080 : (c >= 6 && c <= 9) ? 16'h0004 : 16'h0000;
      exp_w[c] = (c >= 6) ? 2'd2 : (c >= 2) ? 2'd1 : 2'd0;
    end
    stim[1] = 16'h0080; stim[5] = 16'h0004; stim[6] = 16'h0010; stim[10] = 16'h0080;
    for (int c = 0; c < 16; c++) begin
      checks++; if (out1 !== exp_o[c]) $display("FAIL inhibit_out c=%0d got %h want %h", c, out1, exp_o[c]); else passed++;
      checks++; if (wc1 !== exp_w[c]) $display("FAIL inhibit_wc c=%0d got %0d want %0d", c, wc1, exp_w[c]); else passed++;
      in1 = stim[c];
      tick();
    end
  endtask

  task automatic test_truncate();
    logic [15:0] exp_o [16];
    logic [1:0]  exp_w [16];
    for (int c = 0; c < 16; c++) begin
      exp_o[c] = (c >= 14) ? 16'h0002 : 16'h0000;
      exp_w[c] = (c >= 14) ? 2'd1 : 2'd0;
    end
    for (int c = 0; c < 16; c++) begin
      checks++; if (out1 !== exp_o[c]) $display("FAIL trunc_out c=%0d got %h want %h", c, out1, exp_o[c]); else passed++;
      checks++; if (wc1 !== exp_w[c]) $display("FAIL trunc_wc c=%0d got %0d want %0d", c, wc1, exp_w[c]); else passed++;
      in1 = (c == 13) ? 16'h0002 : (c == 15) ? 16'h0040 : 16'h0000;
      tick();
    end
    checks++; if (out1 !== 16'h0000) $display("FAIL trunc_wrap_out got %h want %h", out1, 16'h0000); else passed++;
    checks++; if (wc1 !== 2'd0) $display("FAIL trunc_wrap_wc got %0d want 0", wc1); else passed++;
    in1 = 16'h0000;
    tick();
    checks++; if (out1 !== 16'h0000) $display("FAIL late_rise_out got %h want %h", out1, 16'h0000); else passed++;
    while (cnt != 0) tick();
  endtask

  task automatic test_en_freeze();
    in1 = 16'h0000; tick();
    in1 = 16'h0001; tick();
    in1 = 16'h0000;
    checks++; if (out1 !== 16'h0001) $display("FAIL frz_pre2 got %h want %h", out1, 16'h0001); else passed++;
    tick();
    checks++; if (out1 !== 16'h0001) $display("FAIL frz_pre3 got %h want %h", out1, 16'h0001); else passed++;
    tick();
    checks++; if (out1 !== 16'h0001) $display("FAIL frz_pre4 got %h want %h", out1, 16'h0001); else passed++;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in1 = (i >= 2) ? 16'h0020 : 16'h0000;
      tick();
      checks++; if (out1 !== 16'h0001) $display("FAIL frz_hold i=%0d got %h want %h", i, out1, 16'h0001); else passed++;
      checks++; if (wc1 !== 2'd1) $display("FAIL frz_wc i=%0d got %0d want 1", i, wc1); else passed++;
      checks++; if (gs1 !== 1'b0) $display("FAIL frz_gs i=%0d got %b want 0", i, gs1); else passed++;
    end
    en = 1'b1;
    tick();
    checks++; if (out1 !== 16'h0001) $display("FAIL frz_resume got %h want %h", out1, 16'h0001); else passed++;
    in1 = 16'h0000;
    tick();
    checks++; if (out1 !== 16'h0000) $display("FAIL frz_end got %h want %h", out1, 16'h0000); else passed++;
    while (cnt != 0) begin
      checks++; if (gs1 !== 1'b0) $display("FAIL frz_gs_run c=%0d got %b want 0", cnt, gs1); else passed++;
      tick();
    end
    checks++; if (gs1 !== 1'b1) $display("FAIL frz_wrap_gs got %b want 1", gs1); else passed++;
  endtask

  task automatic test_reset_mid_pulse();
    in1 = 16'h0000; tick();
    in1 = 16'h0100; tick();
    checks++; if (out1 !== 16'h0100) $display("FAIL midrst_pre got %h want %h", out1, 16'h0100); else passed++;
    in1 = 16'h0000;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out1 !== 16'h0000) $display("FAIL midrst_out got %h want %h", out1, 16'h0000); else passed++;
    checks++; if (gs1 !== 1'b1) $display("FAIL midrst_gs got %b want 1", gs1); else passed++;
    checks++; if (wc1 !== 2'd0) $display("FAIL midrst_wc got %0d want 0", wc1); else passed++;
    @(posedge aclk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
  endtask

  task automatic test_tie_rotation();
    logic [15:0] second;
`ifdef WTA_RR_TIE_EN
    second = 16'h0002;
`else
    second = 16'h0001;
`endif
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < 16; c++) begin
        logic [15:0] eo;
        logic [0:0]  ew;
        eo = (c >= 3 && c <= 6) ? ((g == 0) ? 16'h0001 : second) : 16'h0000;
        ew = (c >= 3) ? 1'b1 : 1'b0;
        checks++; if (out2 !== eo) $display("FAIL rr_out g=%0d c=%0d got %h want %h", g, c, out2, eo); else passed++;
        checks++; if (wc2 !== ew) $display("FAIL rr_wc g=%0d c=%0d got %0d want %0d", g, c, wc2, ew); else passed++;
        in2 = (c == 2) ? 16'h0003 : 16'h0000;
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_held_line();
    test_tie();
    test_inhibit();
    test_truncate();
    test_en_freeze();
    test_reset_mid_pulse();
    test_tie_rotation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
